// File: rtl/mem_stage_rsp.sv
// ---------------------------------------------------------------------------
// mem_stage_rsp
//
// Memory pipeline stage that sits between execute and writeback.
//
// Non-load instructions spend one cycle here and pass their ALU result on.
// Loads wait here until the data SRAM returns rvalid. If writeback is stalled
// when the data arrives, the data is held in a one-entry buffer (rdata_buf)
// until the instruction can leave. The stage also drives a forwarding bus and
// a load-pending flag so the decode stage can resolve hazards.
//
// Optional build macro: MS_STALL_CNT_EN
//   When defined, the block adds the output ms_stall_cnt, a saturating 32-bit
//   count of cycles in which a valid instruction was stalled waiting for load
//   data.
//
// Ports
//   clk, resetn        rising-edge clock, asynchronous active-low reset
//   es_to_ms_valid     execute stage offers an instruction
//   es_to_ms_bus[70:0] {res_from_mem, gr_we, dest[4:0], alu_result, pc}
//   ms_allowin         this stage can accept an instruction this cycle
//   ws_allowin         writeback can accept an instruction this cycle
//   ms_to_ws_valid     instruction presented to writeback
//   ms_to_ws_bus[69:0] {gr_we, dest[4:0], final_result, pc}
//   data_sram_rvalid   load data is valid this cycle
//   data_sram_rdata    load data
//   out_ms_valid       raw occupancy flag for decode
//   ms_fwd_bus[38:0]   {fwd_we, fwd_data_ok, dest[4:0], final_result}
//   ms_load_pending    a valid load is still waiting for its data
//   ms_stall_cnt[31:0] stall cycle counter (MS_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module mem_stage_rsp #(
   localparam int ES_TO_MS_BUS_WD = 71,
   localparam int MS_TO_WS_BUS_WD = 70
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_allowin,
   input  logic                       ws_allowin,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_sram_rvalid,
   input  logic [31:0]                data_sram_rdata,
   output logic                       out_ms_valid,
   output logic [38:0]                ms_fwd_bus,
   output logic                       ms_load_pending
`ifdef MS_STALL_CNT_EN
   ,
   output logic [31:0]                ms_stall_cnt
`endif
);

   // State
   logic                       ms_valid_q,  ms_valid_d;
   logic [ES_TO_MS_BUS_WD-1:0] bus_r_q,     bus_r_d;
   logic                       data_got_q,  data_got_d;
   logic [31:0]                rdata_buf_q, rdata_buf_d;
`ifdef MS_STALL_CNT_EN
   logic [31:0]                stall_cnt_q, stall_cnt_d;
`endif

   // Fields of the captured instruction
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;

   logic        ms_ready_go;
   logic        ms_leave;
   logic        rdata_accept;
   logic [31:0] final_result;

   always_comb begin
      res_from_mem = bus_r_q[70];
      gr_we        = bus_r_q[69];
      dest         = bus_r_q[68:64];
      alu_result   = bus_r_q[63:32];
      pc           = bus_r_q[31:0];

      // A load is ready once its data is buffered or arrives this cycle.
      ms_ready_go    = !res_from_mem || data_got_q || data_sram_rvalid;
      ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
      ms_to_ws_valid = ms_valid_q && ms_ready_go;
      ms_leave       = ms_to_ws_valid && ws_allowin;

      // Only the first rvalid for a resident, still-waiting load counts.
      rdata_accept = ms_valid_q && res_from_mem && !data_got_q && data_sram_rvalid;

      if (res_from_mem) begin
         final_result = data_got_q ? rdata_buf_q : data_sram_rdata;
      end else begin
         final_result = alu_result;
      end

      ms_to_ws_bus    = {gr_we, dest, final_result, pc};
      out_ms_valid    = ms_valid_q;
      ms_fwd_bus      = {ms_valid_q && gr_we, ms_ready_go, dest, final_result};
      ms_load_pending = ms_valid_q && res_from_mem && !ms_ready_go;

      // Next state
      ms_valid_d = ms_allowin ? es_to_ms_valid : ms_valid_q;
      bus_r_d    = (es_to_ms_valid && ms_allowin) ? es_to_ms_bus : bus_r_q;

      data_got_d  = data_got_q;
      rdata_buf_d = rdata_buf_q;
      if (ms_leave) begin
         // Leaving clears the flag so whatever enters on this edge starts
         // clean; data accepted on the leaving cycle simply passes through.
         data_got_d = 1'b0;
      end else if (rdata_accept) begin
         data_got_d  = 1'b1;
         rdata_buf_d = data_sram_rdata;
      end

`ifdef MS_STALL_CNT_EN
      stall_cnt_d = stall_cnt_q;
      if (ms_valid_q && !ms_ready_go && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      ms_stall_cnt = stall_cnt_q;
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q  <= 1'b0;
         bus_r_q     <= '0;
         data_got_q  <= 1'b0;
         rdata_buf_q <= '0;
`ifdef MS_STALL_CNT_EN
         stall_cnt_q <= '0;
`endif
      end else begin
         ms_valid_q  <= ms_valid_d;
         bus_r_q     <= bus_r_d;
         data_got_q  <= data_got_d;
         rdata_buf_q <= rdata_buf_d;
`ifdef MS_STALL_CNT_EN
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

endmodule
